// File: rtl/accumulator_pkg.sv
// Shared types and arithmetic helpers for the ping/pong partial-sum accumulator.
package accumulator_pkg;

  typedef enum logic [1:0] {
    BW4     = 2'd0,
    BW8     = 2'd1,
    BW16    = 2'd2,
    BW_RSVD = 2'd3
  } bitwidth_e;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

  function automatic int unsigned elem_width(input bitwidth_e bw);
    case (bw)
      BW4:     return 4;
      BW8:     return 8;
      default: return 16;
    endcase
  endfunction

  // Clamp to the signed ew-bit range; result is ew bits in the LSBs, upper bits zero.
  function automatic logic [15:0] saturate(input logic signed [63:0] acc, input int unsigned ew);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] v;
    logic [15:0]        mask;
    hi = (64'sd1 <<< (ew - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ew - 1));
    if (acc > hi)      v = hi;
    else if (acc < lo) v = lo;
    else               v = acc;
    mask = (ew >= 16) ? 16'hFFFF : 16'((32'd1 << ew) - 32'd1);
    return 16'(v) & mask;
  endfunction

  function automatic logic sat_hit(input logic signed [63:0] acc, input int unsigned ew);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ew - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ew - 1));
    return (acc > hi) || (acc < lo);
  endfunction

endpackage

// File: rtl/accumulator_bank.sv
// One accumulator bank holding both ping/pong copies: accumulate into the active copy,
// read and clear the other. ACC_OVERFLOW_STATUS_EN adds a per-cycle wrap flag.
module accumulator_bank
  import accumulator_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int PRODUCT_WIDTH = 16,
  parameter int ACC_WIDTH     = 24
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              active_sel,
  input  logic                              acc_valid,
  input  logic [$clog2(DEPTH)-1:0]          acc_addr,
  input  logic [PRODUCT_WIDTH-1:0]          acc_data,
  input  logic [DEPTH-1:0]                  clr_mask,
  output logic [DEPTH-1:0][ACC_WIDTH-1:0]   drain_data
`ifdef ACC_OVERFLOW_STATUS_EN
  ,
  output logic                              acc_ovf
`endif
);

  logic [1:0][DEPTH-1:0][ACC_WIDTH-1:0] mem_q;
  logic                                 drain_sel;
  logic signed [ACC_WIDTH-1:0]          addend;
  logic signed [ACC_WIDTH-1:0]          old_val;
  logic signed [ACC_WIDTH-1:0]          sum;

  assign drain_sel = ~active_sel;

  always_comb begin
    addend  = ACC_WIDTH'($signed(acc_data));
    old_val = mem_q[active_sel][acc_addr];
    sum     = old_val + addend;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '0;
    end else begin
      for (int d = 0; d < DEPTH; d++) begin
        if (clr_mask[d]) mem_q[drain_sel][d] <= '0;
      end
      if (acc_valid) mem_q[active_sel][acc_addr] <= sum;
    end
  end

  assign drain_data = mem_q[drain_sel];

`ifdef ACC_OVERFLOW_STATUS_EN
  // Signed wrap: both operands share a sign that the sum does not.
  assign acc_ovf = acc_valid && (old_val[ACC_WIDTH-1] == addend[ACC_WIDTH-1])
                             && (sum[ACC_WIDTH-1] != old_val[ACC_WIDTH-1]);
`endif

endmodule

// File: rtl/accumulator_bank_array.sv
// Double-buffered partial-sum accumulator with saturating, packed valid/ready drain.
// Optional sticky overflow status port under ACC_OVERFLOW_STATUS_EN.
//
// state | meaning
// IDLE  | accumulating only; transfer_ready=1, swap accepted on transfer
// DRAIN | previous tile streams out (read-and-clear), accumulation continues
module accumulator_bank_array
  import accumulator_pkg::*;
#(
  parameter int BANK_COUNT    = 4,
  parameter int BANK_DEPTH    = 16,
  parameter int PRODUCT_WIDTH = 16,
  parameter int ACC_WIDTH     = 24,
  parameter int OUT_WIDTH     = 16
) (
  input  logic                                           clk,
  input  logic                                           reset_n,
  input  logic [BANK_COUNT-1:0]                          acc_valid,
  input  logic [BANK_COUNT-1:0][$clog2(BANK_DEPTH)-1:0]  acc_addr,
  input  logic [BANK_COUNT-1:0][PRODUCT_WIDTH-1:0]       acc_data,
  input  logic [1:0]                                     bitwidth,
  input  logic                                           transfer,
  output logic                                           transfer_ready,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic [OUT_WIDTH-1:0]                           out_data,
  output logic                                           out_last
`ifdef ACC_OVERFLOW_STATUS_EN
  ,
  output logic                                           overflow
`endif
);

  localparam int TOTAL = BANK_COUNT * BANK_DEPTH;
  localparam int PTR_W = $clog2(TOTAL + 1);

  if (ACC_WIDTH < PRODUCT_WIDTH || ACC_WIDTH > 64 || OUT_WIDTH != 16 || (TOTAL % 4) != 0)
  begin : g_param_check
    $error("accumulator_bank_array: unsupported parameter combination");
  end

  drain_state_e state_q, state_d;
  logic         active_sel_q, active_sel_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  bitwidth_e    bw_q, bw_d;

  logic [4:0]   ew;
  logic [2:0]   ne;
  logic         accept;
  logic [TOTAL-1:0]                 clr_flat;
  logic [TOTAL-1:0][ACC_WIDTH-1:0]  drain_flat;
  logic [3:0][ACC_WIDTH-1:0]        elem;
  logic [15:0]                      word;

  assign ew     = 5'(elem_width(bw_q));
  assign ne     = (bw_q == BW4) ? 3'd4 : ((bw_q == BW8) ? 3'd2 : 3'd1);
  assign accept = (state_q == DRAIN) && out_ready;

`ifdef ACC_OVERFLOW_STATUS_EN
  logic [BANK_COUNT-1:0] acc_ovf;
  logic                  sat_any;
  logic                  ovf_q;
`endif

  for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
    accumulator_bank #(
      .DEPTH         (BANK_DEPTH),
      .PRODUCT_WIDTH (PRODUCT_WIDTH),
      .ACC_WIDTH     (ACC_WIDTH)
    ) u_bank (
      .clk        (clk),
      .reset_n    (reset_n),
      .active_sel (active_sel_q),
      .acc_valid  (acc_valid[b]),
      .acc_addr   (acc_addr[b]),
      .acc_data   (acc_data[b]),
      .clr_mask   (clr_flat[b*BANK_DEPTH +: BANK_DEPTH]),
      .drain_data (drain_flat[b*BANK_DEPTH +: BANK_DEPTH])
`ifdef ACC_OVERFLOW_STATUS_EN
      ,
      .acc_ovf    (acc_ovf[b])
`endif
    );
  end

  // Linear entry index = bank*BANK_DEPTH + addr; a word may straddle two banks.
  always_comb begin
    elem     = '0;
    clr_flat = '0;
    for (int i = 0; i < 4; i++) begin
      for (int e = 0; e < TOTAL; e++) begin
        if (e == int'(ptr_q) + i) elem[i] = drain_flat[e];
      end
    end
    for (int e = 0; e < TOTAL; e++) begin
      clr_flat[e] = accept && (e >= int'(ptr_q)) && (e < int'(ptr_q) + int'(ne));
    end
  end

  always_comb begin
    logic [15:0] sat_w;
    word  = '0;
    sat_w = '0;
`ifdef ACC_OVERFLOW_STATUS_EN
    sat_any = 1'b0;
`endif
    for (int i = 0; i < 4; i++) begin
      if (i < int'(ne)) begin
        sat_w = saturate(64'($signed(elem[i])), 32'(ew));
        word  = word | (sat_w << (i * int'(ew)));
`ifdef ACC_OVERFLOW_STATUS_EN
        sat_any = sat_any | sat_hit(64'($signed(elem[i])), 32'(ew));
`endif
      end
    end
  end

  assign out_valid      = (state_q == DRAIN);
  assign transfer_ready = (state_q == IDLE);
  assign out_data       = (state_q == DRAIN) ? word : '0;
  assign out_last       = (state_q == DRAIN) && (int'(ptr_q) + int'(ne) == TOTAL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      active_sel_q <= 1'b0;
      ptr_q        <= '0;
      bw_q         <= BW16;
    end else begin
      state_q      <= state_d;
      active_sel_q <= active_sel_d;
      ptr_q        <= ptr_d;
      bw_q         <= bw_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    active_sel_d = active_sel_q;
    ptr_d        = ptr_q;
    bw_d         = bw_q;
    case (state_q)
      IDLE: begin
        if (transfer) begin
          active_sel_d = ~active_sel_q;
          ptr_d        = '0;
          bw_d         = bitwidth_e'(bitwidth);
          state_d      = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          ptr_d = ptr_q + PTR_W'(ne);
          if (out_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ACC_OVERFLOW_STATUS_EN
  // A new event in the same cycle as a swap keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                ovf_q <= 1'b0;
    else if ((|acc_ovf) || (accept && sat_any))  ovf_q <= 1'b1;
    else if ((state_q == IDLE) && transfer)      ovf_q <= 1'b0;
  end

  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_accumulator_bank_array.sv
// Randomised self-checking bench against an array-based model of the ping/pong accumulator.
module tb_accumulator_bank_array;

  localparam int  BC    = 4;
  localparam int  BD    = 16;
  localparam int  TOTAL = BC * BD;
  localparam longint AMAX = 64'sd8388607;
  localparam longint AMIN = -64'sd8388608;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [BC-1:0]      acc_valid;
  logic [BC-1:0][3:0] acc_addr;
  logic [BC-1:0][15:0] acc_data;
  logic [1:0]         bitwidth;
  logic               transfer;
  logic               transfer_ready;
  logic               out_valid;
  logic               out_ready;
  logic [15:0]        out_data;
  logic               out_last;
`ifdef ACC_OVERFLOW_STATUS_EN
  logic               overflow;
`endif

  always #5 clk = ~clk;

  accumulator_bank_array dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .acc_valid      (acc_valid),
    .acc_addr       (acc_addr),
    .acc_data       (acc_data),
    .bitwidth       (bitwidth),
    .transfer       (transfer),
    .transfer_ready (transfer_ready),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last)
`ifdef ACC_OVERFLOW_STATUS_EN
    ,
    .overflow       (overflow)
`endif
  );

  int errors = 0;
  int checks = 0;

  longint m_buf [2][TOTAL];
  int     m_sel;
  bit     m_drain;
  int     m_ptr;
  int     m_bw;
  bit     m_ovf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint wrap24(input longint s);
    longint u;
    u = s & 64'hFFFFFF;
    if (u >= 64'sd8388608) u = u - 64'sd16777216;
    return u;
  endfunction

  function automatic int epw(input int bw);
    return (bw == 0) ? 4 : ((bw == 1) ? 2 : 1);
  endfunction

  function automatic longint clamp(input longint v, input int ew);
    longint hi, lo;
    hi = (64'sd1 <<< (ew - 1)) - 1;
    lo = -(64'sd1 <<< (ew - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  function automatic logic [15:0] exp_word();
    longint w, c;
    int e, ew;
    e  = epw(m_bw);
    ew = 16 / e;
    w  = 0;
    for (int i = 0; i < e; i++) begin
      c = clamp(m_buf[1-m_sel][m_ptr+i], ew);
      w = w | ((c & ((64'sd1 <<< ew) - 1)) <<< (i * ew));
    end
    return 16'(w);
  endfunction

  function automatic bit exp_sat();
    int e;
    bit s;
    e = epw(m_bw);
    s = 0;
    for (int i = 0; i < e; i++) begin
      if (clamp(m_buf[1-m_sel][m_ptr+i], 16 / e) != m_buf[1-m_sel][m_ptr+i]) s = 1;
    end
    return s;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++)
      for (int e = 0; e < TOTAL; e++) m_buf[s][e] = 0;
    m_sel = 0; m_drain = 0; m_ptr = 0; m_bw = 2; m_ovf = 0;
  endtask

  task automatic idle_inputs();
    acc_valid = '0; acc_addr = '0; acc_data = '0; transfer = 1'b0;
  endtask

  // Check outputs against the model, advance the model by this edge's inputs, then clock.
  task automatic tick();
    bit ev;
    longint s;
    int idx;
    check("transfer_ready", transfer_ready, 64'(!m_drain));
    check("out_valid", out_valid, 64'(m_drain));
    check("out_data", out_data, m_drain ? 64'(exp_word()) : 64'd0);
    check("out_last", out_last, 64'(m_drain && (m_ptr + epw(m_bw) == TOTAL)));
`ifdef ACC_OVERFLOW_STATUS_EN
    check("overflow", overflow, 64'(m_ovf));
`endif
    if (reset_n) begin
      ev = 0;
      for (int b = 0; b < BC; b++) begin
        if (acc_valid[b]) begin
          idx = b * BD + int'(acc_addr[b]);
          s   = m_buf[m_sel][idx] + longint'($signed(acc_data[b]));
          if (s > AMAX || s < AMIN) ev = 1;
          m_buf[m_sel][idx] = wrap24(s);
        end
      end
      if (m_drain) begin
        if (out_ready) begin
          if (exp_sat()) ev = 1;
          for (int i = 0; i < epw(m_bw); i++) m_buf[1-m_sel][m_ptr+i] = 0;
          m_ptr = m_ptr + epw(m_bw);
          if (m_ptr == TOTAL) m_drain = 0;
        end
      end else if (transfer) begin
        m_sel = 1 - m_sel; m_ptr = 0; m_bw = int'(bitwidth); m_drain = 1; m_ovf = 0;
      end
      if (ev) m_ovf = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_acc();
    acc_valid = 4'($urandom);
    for (int b = 0; b < BC; b++) begin
      acc_addr[b] = 4'($urandom_range(0, 15));
      acc_data[b] = 16'($urandom);
    end
  endtask

  task automatic single_acc(input int b, input int addr, input logic [15:0] data);
    idle_inputs();
    acc_valid[b] = 1'b1; acc_addr[b] = 4'(addr); acc_data[b] = data;
    tick();
  endtask

  task automatic start_drain(input logic [1:0] bw);
    idle_inputs();
    bitwidth = bw; transfer = 1'b1;
    tick();
    transfer = 1'b0;
  endtask

  // mode 0: ready always; 1: ready toggles, bank1 addr0 +=1, transfer held high; 2: random
  task automatic run_drain(input int mode);
    int n;
    n = 0;
    while (m_drain && n < 2000) begin
      idle_inputs();
      case (mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = n[0] ? 1'b0 : 1'b1;
          acc_valid[1] = 1'b1; acc_addr[1] = 4'd0; acc_data[1] = 16'd1;
          transfer = 1'b1;
        end
        default: begin
          out_ready = 1'($urandom);
          rand_acc();
          transfer = 1'($urandom);
        end
      endcase
      tick();
      n++;
    end
    check("drain_finished", out_valid, 64'd0);
    idle_inputs();
    out_ready = 1'b0;
  endtask

  initial begin
    idle_inputs();
    bitwidth  = 2'd2;
    out_ready = 1'b0;
    model_reset();
    tick();
    tick();
    reset_n = 1'b1;
    check("rst_transfer_ready", transfer_ready, 64'd1);
    check("rst_out_data", out_data, 64'd0);
    tick();

    // Back-to-back hits on one entry, 16b drain.
    single_acc(0, 3, 16'd5);
    single_acc(0, 3, 16'd7);
    single_acc(0, 3, 16'hFFFE);
    start_drain(2'd2);
    for (int k = 0; k < TOTAL; k++) begin
      out_ready = 1'b1;
      if (k == 3)  check("t1_word3", out_data, 64'h000A);
      if (k == 62) check("t1_last_early", out_last, 64'd0);
      if (k == 63) check("t1_last", out_last, 64'd1);
      tick();
    end
    out_ready = 1'b0;

    // 4b packing with saturation in both directions.
    single_acc(0, 0, 16'd3);
    single_acc(0, 1, 16'hFFF7);
    single_acc(0, 2, 16'd8);
    single_acc(0, 3, 16'hFFF8);
    start_drain(2'd0);
    check("bw4_word0", out_data, 64'h8783);
    run_drain(0);

    // Stalled drain with concurrent accumulation and ignored transfer.
    start_drain(2'd2);
    run_drain(1);
    start_drain(2'd2);
    run_drain(0);
    start_drain(2'd1);
    run_drain(0);

    // Accumulator wraps past 2^23-1.
    for (int k = 0; k < 260; k++) single_acc(2, 5, 16'h7FFF);
    check("wrap_negative", 64'(m_buf[m_sel][2*BD+5] < 0), 64'd1);
    start_drain(2'd2);
    run_drain(0);
    start_drain(2'd3);
    run_drain(2);

    // Random tiles.
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 30; k++) begin
        idle_inputs();
        rand_acc();
        tick();
      end
      start_drain(2'($urandom_range(0, 3)));
      run_drain(2);
    end

    // Reset in the middle of a drain.
    for (int k = 0; k < 40; k++) begin
      idle_inputs();
      rand_acc();
      tick();
    end
    start_drain(2'd2);
    while (m_drain && m_ptr < 20) begin
      out_ready = 1'b1;
      tick();
    end
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 64'd0);
    check("midrst_transfer_ready", transfer_ready, 64'd1);
    idle_inputs();
    out_ready = 1'b0;
    model_reset();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    start_drain(2'd2);
    run_drain(2);
    start_drain(2'd0);
    run_drain(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/accumulator_bank_array.md
Name: accumulator_bank_array

Overview:
Double-buffered (ping/pong) partial-sum accumulator. It generalises the front/back accumulator banks to parametrised bank count, depth and accumulator width, and adds runtime output precision with saturating, packed drain. PE crossbar results accumulate into the active buffer while the previous tile's buffer drains over a valid/ready stream to the output activation writer. Each drained entry is cleared as it is read.

Parameters:
BANK_COUNT, 4, number of independent banks, each with one accumulate port per cycle
BANK_DEPTH, 16, entries per bank per buffer
PRODUCT_WIDTH, 16, signed width of incoming partial products
ACC_WIDTH, 24, signed accumulator entry width; must be >= PRODUCT_WIDTH
OUT_WIDTH, 16, drain word width; must be 16 (holds 4x4b, 2x8b or 1x16b elements)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
acc_valid[BANK_COUNT]  in  1  accumulate request per bank
acc_addr[BANK_COUNT]  in  $clog2(BANK_DEPTH)  entry index within bank
acc_data[BANK_COUNT]  in  PRODUCT_WIDTH  signed partial product
bitwidth  in  2  drain element width: 0=4b, 1=8b, 2=16b, 3=reserved (treated as 16b)
transfer  in  1  request buffer swap at end of tile
transfer_ready  out  1  high when swap can be accepted (drain idle)
out_valid  out  1  drain word available
out_ready  in  1  downstream accepts word
out_data  out  OUT_WIDTH  packed saturated elements; element 0 in LSBs
out_last  out  1  marks final word of the drained tile
overflow  out  1  sticky status (present only with ACC_OVERFLOW_STATUS_EN)

Behaviour:
- Reset (async, any time including mid-drain): both buffers cleared to 0, active_sel=0, FSM=IDLE. Outputs reset: out_valid=0, out_last=0, out_data=0, transfer_ready=1, overflow=0.
- Accumulate: for each bank b with acc_valid[b]=1, active[b][acc_addr[b]] += sign_extend(acc_data[b]) at the rising edge. Result is visible to a same-address request in the next cycle; back-to-back hits need no stall. Sum wraps modulo 2^ACC_WIDTH (two's complement). Banks are independent.
- FSM IDLE: transfer_ready=1, out_valid=0. If transfer=1, then at the edge: active_sel toggles, ptr=0, FSM -> DRAIN. Accumulates in the same cycle land in the old active buffer, which becomes the drain buffer.
- FSM DRAIN: transfer_ready=0 and transfer is ignored. Accumulates continue into the new active buffer. out_valid=1.
- Element width ew = 4/8/16 from bitwidth; E = 16/ew elements per word (4/2/1).
- bitwidth is sampled at the transfer edge and held for the whole drain.
- Linear entry order: index = bank*BANK_DEPTH + addr. Word k packs entries k*E .. k*E+E-1, element i at bits [i*ew +: ew].
- Each element saturates to [-2^(ew-1), 2^(ew-1)-1].
- out_data is combinational from the drain buffer at ptr.
- On out_valid && out_ready: the E entries are cleared to 0 and ptr advances by E.
- out_last=1 when ptr+E == BANK_COUNT*BANK_DEPTH. On accept of the last word, FSM -> IDLE.
- BANK_COUNT*BANK_DEPTH must be a multiple of 4 (elaboration-time assertion).
- out_valid stalls arbitrarily: out_data and out_last hold stable while out_ready=0.

Optional Feature:
ACC_OVERFLOW_STATUS_EN:
- Defined: overflow port exists. It sets (sticky) when any accumulate overflows ACC_WIDTH signed range, or any drained element saturates. It clears on an accepted transfer; an event in the same cycle as the accept wins and overflow stays 1.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package accumulator_pkg: bitwidth_e enum (BW4, BW8, BW16, BW_RSVD), drain_state_e (IDLE, DRAIN), function elem_width(bitwidth_e), function saturate(acc, ew).
- Sub-module accumulator_bank: one bank, both ping/pong copies, accumulate port plus a drain read/clear port selected by active_sel. Instantiated BANK_COUNT times via generate.
- Top level holds the FSM, ptr and packing mux.

Test Plan:
- Bank0 addr3 += 5, +7, -2 on consecutive cycles; transfer; bitwidth=2 -> word for entry 3 has out_data=16'h000A; all other words are 0; out_last only on word 63.
- bitwidth=0, entries 0..3 = 3, -9, 8, -8 -> first word 16'h8783 (sat 7,-8,-8? check: 3=3, -9->-8=8, 8->7=7, -8=8) = 16'h8783; overflow=1 with macro.
- Drain with out_ready toggling 1/0 every cycle while accumulating into bank1 addr0 += 1 each cycle -> no lost or duplicate words; the next drain shows the exact count in bank1 addr0.
- transfer asserted during DRAIN -> ignored, transfer_ready=0. After the last accept, transfer_ready=1 and a second transfer swaps back, with the original buffer reading all zeros.
- Accumulate 0x7FFF repeatedly to exceed 2^23-1 -> value wraps negative; overflow sets; cleared on next accepted transfer.
- Assert reset_n=0 mid-drain at ptr=20 -> out_valid=0 immediately; after release, transfer drains all zeros.
